// File: rtl/led_chaser_monitor_if.sv
// rtl/led_chaser_monitor_if.sv - LED bus, clear strobe and monitor status grouped for the chaser monitor
interface led_chaser_monitor_if #(
  parameter int CNT_W = 16
);
  logic             led1;
  logic             led2;
  logic             led3;
  logic             led4;
  logic             clr;
  logic [1:0]       pos;
  logic             dir_det;
  logic             valid;
  logic             step;
  logic             rev;
  logic [CNT_W-1:0] step_cnt;
  logic             error;
  logic [1:0]       err_code;

  modport master (
    output led1, led2, led3, led4, clr,
    input  pos, dir_det, valid, step, rev, step_cnt, error, err_code
  );

  modport slave (
    input  led1, led2, led3, led4, clr,
    output pos, dir_det, valid, step, rev, step_cnt, error, err_code
  );
endinterface

// File: rtl/led_chaser_monitor.sv
// rtl/led_chaser_monitor.sv - 4-LED chaser observer: position/direction/step decode with sticky fault
// Optional stall timeout enabled by defining LED_MONITOR_STALL_TIMEOUT_EN.
module led_chaser_monitor #(
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 1000
) (
  input  logic              clk,
  input  logic              rst,
  led_chaser_monitor_if.slave bus
);

  typedef enum logic [1:0] {S_SEARCH, S_TRACK, S_FAULT} state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_ONEHOT = 2'b01;
  localparam logic [1:0] ERR_SKIP   = 2'b10;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
  localparam logic [1:0] ERR_STALL  = 2'b11;
  localparam int         SW         = $clog2(STALL_MAX + 1);
  logic [SW-1:0] stall_q, stall_d;
`else
  logic unused_stall_max;
  assign unused_stall_max = (STALL_MAX != 0);
`endif

  state_e           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;
  logic             rev_q, rev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       prev_q, prev_d;
  logic             seen_q, seen_d;

  logic [3:0] p;
  logic       one_hot;
  logic [1:0] idx;

  assign p       = {bus.led4, bus.led3, bus.led2, bus.led1};
  assign one_hot = (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);

  always_comb begin
    idx = 2'd0;
    if (p[1]) idx = 2'd1;
    if (p[2]) idx = 2'd2;
    if (p[3]) idx = 2'd3;
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    step_d  = 1'b0;
    rev_d   = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    code_d  = code_q;
    prev_d  = prev_q;
    seen_d  = seen_q;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
    stall_d = stall_q;
`endif
    case (state_q)
      S_SEARCH: begin
        if (one_hot) begin
          state_d = S_TRACK;
          pos_d   = idx;
          prev_d  = p;
          valid_d = 1'b1;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      S_TRACK: begin
        if (p == prev_q) begin
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
          stall_d = stall_q + SW'(1);
          if (stall_d == SW'(STALL_MAX)) begin
            state_d = S_FAULT;
            valid_d = 1'b0;
            err_d   = 1'b1;
            code_d  = ERR_STALL;
          end
`endif
        end else if (!one_hot) begin
          state_d = S_FAULT;
          valid_d = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_ONEHOT;
        end else if (idx == pos_q + 2'd2) begin
          state_d = S_FAULT;
          valid_d = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_SKIP;
        end else begin
          // Only +1/-1 remain here; wrap falls out of the 2-bit arithmetic.
          pos_d  = idx;
          prev_d = p;
          dir_d  = (idx != pos_q + 2'd1);
          step_d = 1'b1;
          rev_d  = seen_q && (dir_d != dir_q);
          seen_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_q <= S_SEARCH;
      pos_q   <= 2'd0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      rev_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      prev_q  <= 4'b0000;
      seen_q  <= 1'b0;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      rev_q   <= rev_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      prev_q  <= prev_d;
      seen_q  <= seen_d;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign bus.pos      = pos_q;
  assign bus.dir_det  = dir_q;
  assign bus.valid    = valid_q;
  assign bus.step     = step_q;
  assign bus.rev      = rev_q;
  assign bus.step_cnt = cnt_q;
  assign bus.error    = err_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_led_chaser_monitor.sv
// tb/tb_led_chaser_monitor.sv - scoreboard bench for led_chaser_monitor with a behavioural reference model
module tb_led_chaser_monitor;
  localparam int CNT_W = 4;
`ifdef LED_MONITOR_STALL_TIMEOUT_EN
  localparam int STALL_MAX = 8;
  localparam bit STALL_EN  = 1'b1;
`else
  localparam int STALL_MAX = 1000;
  localparam bit STALL_EN  = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]       pos;
    logic             dir;
    logic             valid;
    logic             step;
    logic             rev;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic [1:0]       code;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_chaser_monitor_if #(.CNT_W(CNT_W)) bus ();

  led_chaser_monitor #(.CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 1'b0;

  // Reference model: mode 0 = searching, 1 = tracking, 2 = faulted.
  int       m_mode, m_pos, m_dir, m_valid, m_cnt, m_err, m_code, m_seen, m_stall;
  int       m_step, m_rev;
  bit [3:0] m_prev;

  function automatic int bits_set(bit [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  function automatic int index_of(bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_fault(input int code);
    m_mode = 2; m_err = 1; m_code = code; m_valid = 0;
  endtask

  task automatic model_edge(input bit [3:0] p, input bit c, input bit r);
    int delta;
    m_step = 0; m_rev = 0;
    if (r || c) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_valid = 0; m_cnt = 0;
      m_err = 0; m_code = 0; m_seen = 0; m_stall = 0; m_prev = 4'b0000;
    end else if (m_mode == 0) begin
      if (bits_set(p) == 1) begin
        m_mode = 1; m_pos = index_of(p); m_prev = p; m_valid = 1; m_stall = 0;
      end
    end else if (m_mode == 1) begin
      if (bits_set(p) != 1) begin
        model_fault(1);
      end else if (p == m_prev) begin
        m_stall++;
        if (STALL_EN && m_stall == STALL_MAX) model_fault(3);
      end else begin
        delta = (index_of(p) - m_pos + 4) % 4;
        if (delta == 2) begin
          model_fault(2);
        end else begin
          m_rev  = (m_seen == 1 && m_dir != (delta == 3 ? 1 : 0)) ? 1 : 0;
          m_dir  = (delta == 3) ? 1 : 0;
          m_pos  = index_of(p);
          m_prev = p;
          m_step = 1;
          m_seen = 1;
          m_stall = 0;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end
  endtask

  task automatic apply(input bit [3:0] p, input int n, input bit c = 1'b0, input bit r = 1'b0);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      {bus.led4, bus.led3, bus.led2, bus.led1} = p;
      bus.clr = c;
      rst     = r;
      model_edge(p, c, r);
      e.pos = 2'(m_pos); e.dir = 1'(m_dir); e.valid = 1'(m_valid);
      e.step = 1'(m_step); e.rev = 1'(m_rev); e.cnt = CNT_W'(m_cnt);
      e.err = 1'(m_err); e.code = 2'(m_code);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every clock edge presents a fresh output word; compare it 2 time units later.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.pos = bus.pos; a.dir = bus.dir_det; a.valid = bus.valid;
        a.step = bus.step; a.rev = bus.rev; a.cnt = bus.step_cnt;
        a.err = bus.error; a.code = bus.err_code;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got pos=%0d dir=%0b valid=%0b step=%0b rev=%0b cnt=%0d err=%0b code=%0d, expected pos=%0d dir=%0b valid=%0b step=%0b rev=%0b cnt=%0d err=%0b code=%0d",
                   $time, a.pos, a.dir, a.valid, a.step, a.rev, a.cnt, a.err, a.code,
                   e.pos, e.dir, e.valid, e.step, e.rev, e.cnt, e.err, e.code);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, stim_done=%0b required 1", stim_done);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    bit [3:0] p;
    bus.led1 = 1'b0; bus.led2 = 1'b0; bus.led3 = 1'b0; bus.led4 = 1'b0;
    bus.clr = 1'b0;

    apply(4'b0000, 2, 1'b0, 1'b1);
    apply(4'b0000, 5);
    apply(4'b0001, 4); apply(4'b0010, 4); apply(4'b0100, 4);
    apply(4'b1000, 4); apply(4'b0001, 4);
    apply(4'b0010, 2); apply(4'b0100, 2);
    apply(4'b0010, 2); apply(4'b0001, 2);
    apply(4'b0010, 2);
    apply(4'b1000, 4);
    apply(4'b0011, 1, 1'b1);
    apply(4'b0000, 3);
    apply(4'b0001, 2);
    apply(4'b0110, 2);
    for (int i = 0; i < 10; i++) apply(4'b0001 << (i % 4), 1);
    apply(4'b0001, 1, 1'b0, 1'b1);
    apply(4'b0000, 2);
    apply(4'b0100, 100);
    apply(4'b0000, 1, 1'b1);
    for (int i = 0; i < 20; i++) apply(4'b0001 << (i % 4), 1);

    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        apply(4'($urandom_range(0, 15)), 1, 1'b0, 1'b1);
      end else if (r < 4 || (m_mode == 2 && r < 25)) begin
        apply(4'($urandom_range(0, 15)), 1, 1'b1);
      end else if (r < 8) begin
        apply(4'($urandom_range(0, 15)), 1);
      end else if (m_mode == 0) begin
        p = 4'b0001 << $urandom_range(0, 3);
        apply(p, 1);
      end else begin
        case ($urandom_range(0, 3))
          0:       p = 4'b0001 << m_pos;
          2:       p = 4'b0001 << ((m_pos + 3) % 4);
          default: p = 4'b0001 << ((m_pos + 1) % 4);
        endcase
        apply(p, 1);
      end
    end

    @(negedge clk);
    @(negedge clk);
    stim_done = 1'b1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected words left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_chaser_monitor.md
Name: led_chaser_monitor

Overview:
- Observer for the 4-LED chaser's output bus.
- Samples led1..led4 on every clk edge and decodes the active position, the direction of travel and step events.
- Flags illegal patterns (not one-hot, position jumps) with a sticky error.
- Used in-system as a self-check next to the chaser, and as the checker inside chaser benches.

Parameters:
- CNT_W, 16, width of step counter step_cnt; wraps modulo 2^CNT_W.
- STALL_MAX, 1000, clk cycles without a step before a stall fault (used only with STALL_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- led1  input  1  chaser LED, position 0
- led2  input  1  chaser LED, position 1
- led3  input  1  chaser LED, position 2
- led4  input  1  chaser LED, position 3
- clr  input  1  synchronous clear of fault, counter and lock; one-cycle pulse
- pos  output  2  last accepted position, 0..3
- dir_det  output  1  direction of last step: 0 = increment (led1->led2), 1 = decrement
- valid  output  1  monitor locked, pos/dir_det meaningful
- step  output  1  one-cycle pulse per accepted step
- rev  output  1  one-cycle pulse when a step's direction differs from the previous step
- step_cnt  output  CNT_W  accepted steps since reset/clr
- error  output  1  sticky fault flag
- err_code  output  2  00 none, 01 not one-hot, 10 skip (jump by 2), 11 stall

Behaviour:
- Inputs are sampled directly: p = {led4,led3,led2,led1}.
- All outputs are registered. A change on p before edge N is reflected after edge N (latency 1 cycle).
- Internal state: prev (last accepted 4-bit pattern) and a dir_seen flag (a step has occurred since lock).
- Reset (rst=1 at an edge): state=SEARCH, pos=0, dir_det=0, valid=0, step=0, rev=0, step_cnt=0, error=0, err_code=00, prev=0000, dir_seen=0. rst overrides clr and everything else.
- clr=1 at an edge (rst=0): identical to reset. Takes priority over any detection in the same cycle.
- SEARCH:
  - p one-hot -> pos=index(p), prev=p, valid=1, go TRACK. No step pulse.
  - Otherwise -> stay; no error (all-zero at power-up is legal here).
- TRACK, evaluated each cycle:
  - p==prev: hold, step=0.
  - p one-hot, index = pos+1 mod 4: accept. pos updates, prev=p, dir_det=0, step=1, step_cnt+1.
  - p one-hot, index = pos-1 mod 4: accept as above, dir_det=1.
  - On an accepted step: rev=1 if dir_seen=1 and the new dir_det differs from the old dir_det. dir_seen is set to 1 after the first step.
  - Wrap-around is legal: 3->0 is an increment, 0->3 is a decrement.
  - p not one-hot (0000 or >=2 bits set): go FAULT, err_code=01.
  - p one-hot with index = pos+2 mod 4: go FAULT, err_code=10.
- FAULT:
  - error=1, valid=0, step=0, rev=0.
  - pos, dir_det and step_cnt hold their last good values. Inputs are ignored.
  - Exit only via clr or rst, both going to SEARCH.
- step and rev are high only in the cycle of acceptance.
- step_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Direction reversal is not a fault.

Optional Feature:
- Macro: LED_MONITOR_STALL_TIMEOUT_EN.
- Defined:
  - A stall counter (width $clog2(STALL_MAX+1)) runs only in TRACK.
  - It clears to 0 on entry to TRACK and on every accepted step; otherwise it increments.
  - When it reaches STALL_MAX with no step that cycle: go FAULT, err_code=11.
  - A step in the same cycle wins over the stall.
- Undefined:
  - No stall counter; err_code 11 is never produced.
  - A frozen but legal pattern holds TRACK indefinitely.
  - Ports are identical in both builds.

Test Plan:
- rst=1 for 2 cycles with leds=0000, then 0000 for 5 cycles -> all outputs 0, state SEARCH, error=0.
- Drive 0001,0010,0100,1000,0001, each held 4 cycles -> valid=1 after the first edge; four step pulses, each 1 cycle wide; dir_det=0; pos sequence 0,1,2,3,0; step_cnt=4; rev never asserted.
- From pos=2 increasing, drive 0010 then 0001 -> dir_det=1; rev=1 on the 0010 step only; step_cnt increments by 2.
- In TRACK at pos=1, drive 1000 -> error=1, err_code=10, valid=0, pos stays 1. Then clr=1 together with leds=0011 -> SEARCH, error=0, step_cnt=0, no new fault.
- In TRACK, drive 0110 -> err_code=01 sticky. Then legal patterns for 10 cycles -> no change. Then rst=1 mid-fault -> all outputs at reset values next cycle.
- With LED_MONITOR_STALL_TIMEOUT_EN, STALL_MAX=8: hold 0100 in TRACK -> err_code=11 exactly 8 cycles after lock. Without the macro, the same stimulus -> error stays 0 for 100 cycles.
